// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB2 master between NUM_REQ requesters.
// Latches the winner's command, drives the master until done/error/timeout, then releases.
module apb_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        done,
   output logic                        err,
   output logic [DATA_W-1:0]           rdata,
   output logic                        transfer,
   output logic                        READ_WRITE,
   output logic [ADDR_W-1:0]           apb_read_paddr,
   output logic [ADDR_W-1:0]           apb_write_paddr,
   output logic [DATA_W-1:0]           apb_write_data,
   input  logic                        PENABLE,
   input  logic                        PREADY,
   input  logic                        PSLVERR,
   input  logic [DATA_W-1:0]           apb_read_data_out
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [TMR_W-1:0]   timer;

   logic [PTR_W-1:0]   win;
   logic               found;
   int unsigned        idx;
   logic [NUM_REQ-1:0] win_oh;
   logic               win_rw;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_wdata;

   // First requester after the last grant, searching circularly.
   always_comb begin
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      win_oh    = '0;
      win_rw    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!found && req[PTR_W'(idx)]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win == PTR_W'(i)) begin
            win_oh[i] = 1'b1;
            win_rw    = req_rw[i];
            win_addr  = req_addr[i*ADDR_W +: ADDR_W];
            win_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state           <= IDLE;
         ptr             <= PTR_W'(NUM_REQ - 1);
         timer           <= '0;
         gnt             <= '0;
         done            <= 1'b0;
         err             <= 1'b0;
         rdata           <= '0;
         transfer        <= 1'b0;
         READ_WRITE      <= 1'b0;
         apb_read_paddr  <= '0;
         apb_write_paddr <= '0;
         apb_write_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt             <= win_oh;
                  ptr             <= win;
                  READ_WRITE      <= win_rw;
                  apb_read_paddr  <= win_addr;
                  apb_write_paddr <= win_addr;
                  apb_write_data  <= win_wdata;
                  transfer        <= 1'b1;
                  timer           <= '0;
                  state           <= BUSY;
               end
            end
            // Slave error beats completion, completion beats timeout.
            BUSY: begin
               timer <= timer + 1'b1;
               if (PSLVERR) begin
                  done     <= 1'b1;
                  err      <= 1'b1;
                  rdata    <= '0;
                  transfer <= 1'b0;
                  state    <= RELEASE;
               end else if (PENABLE && PREADY) begin
                  done     <= 1'b1;
                  err      <= 1'b0;
                  rdata    <= READ_WRITE ? apb_read_data_out : '0;
                  transfer <= 1'b0;
                  state    <= RELEASE;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  done     <= 1'b1;
                  err      <= 1'b1;
                  rdata    <= '0;
                  transfer <= 1'b0;
                  state    <= RELEASE;
               end
            end
            // One cycle with transfer low lets the master drain back to IDLE.
            RELEASE: begin
               gnt   <= '0;
               timer <= '0;
               done  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
